// File: rtl/cnn_classifier_if.sv
// Handshake and load bus for cnn_classifier: start/busy, pixel windows,
// store loading and the result handshake.
interface cnn_classifier_if;
    logic            classify;
    logic            busy;
    logic [3:0][7:0] pixels;
    logic            pix_valid;
    logic            pix_ready;
    logic            ld_valid;
    logic            ld_kernel;
    logic [7:0]      ld_addr;
    logic [31:0]     ld_data;
    logic            res_valid;
    logic            res_ready;
    logic [7:0]      result;
    logic [23:0]     score;

    modport master (
        output classify, pixels, pix_valid, ld_valid, ld_kernel, ld_addr, ld_data, res_ready,
        input  busy, pix_ready, res_valid, result, score
    );

    modport slave (
        input  classify, pixels, pix_valid, ld_valid, ld_kernel, ld_addr, ld_data, res_ready,
        output busy, pix_ready, res_valid, result, score
    );
endinterface

// File: rtl/cnn_classifier.sv
// 2x2-kernel convolution + max-pool + sequential fully connected classifier.
// Optional build macro NN_CONV_SAT_EN selects the saturating sum>>8 conv scale.
module cnn_classifier #(
    parameter int unsigned NUM_KERNELS   = 2,
    parameter int unsigned NUM_SHAPES    = 4,
    parameter int unsigned WIN_PER_FRAME = 16,
    parameter int unsigned POOL_LEN      = 4
) (
    input  logic              clk,
    input  logic              rst,
    cnn_classifier_if.slave   bus
);
    localparam int unsigned GROUPS    = WIN_PER_FRAME / POOL_LEN;
    localparam int unsigned FEAT_LEN  = NUM_KERNELS * GROUPS;
    localparam int unsigned WPS       = FEAT_LEN / 4;
    localparam int unsigned NUM_WORDS = NUM_SHAPES * WPS;
    localparam int unsigned K_W       = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
    localparam int unsigned S_W       = (NUM_SHAPES > 1) ? $clog2(NUM_SHAPES) : 1;
    localparam int unsigned F_W       = $clog2(FEAT_LEN);
    localparam int unsigned P_W       = (POOL_LEN > 1) ? $clog2(POOL_LEN) : 1;
    localparam int unsigned G_W       = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned A_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned SUM_W     = 18;
    localparam int unsigned ACC_W     = 24;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_FC, S_RES} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               pix_ready_q, pix_ready_d;
    logic               res_valid_q, res_valid_d;

    logic [31:0]        kernel_q [NUM_KERNELS];
    logic [31:0]        weight_q [NUM_WORDS];
    logic [7:0]         feat_q   [FEAT_LEN];
    logic [7:0]         pool_q   [NUM_KERNELS];
    logic [P_W-1:0]     pool_pos_q;
    logic [G_W-1:0]     group_q;
    logic [F_W-1:0]     f_idx_q;
    logic [S_W-1:0]     s_idx_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   best_q;
    logic [7:0]         result_q;

    logic               accept_c, pool_end_c, last_win_c, last_f_c, last_s_c;
    logic               ld_kern_ok_c, ld_wt_ok_c;
    logic [SUM_W-1:0]   sum_c      [NUM_KERNELS];
    logic [7:0]         conv_c     [NUM_KERNELS];
    logic [7:0]         pool_nxt_c [NUM_KERNELS];
    logic [A_W-1:0]     w_addr_c;
    logic [31:0]        w_word_c;
    logic [7:0]         w_byte_c;
    logic [15:0]        prod_c;
    logic [ACC_W-1:0]   total_c;
    logic               better_c;

    assign accept_c     = (state_q == S_CONV) && bus.pix_valid;
    assign pool_end_c   = (pool_pos_q == P_W'(POOL_LEN - 1));
    assign last_win_c   = pool_end_c && (group_q == G_W'(GROUPS - 1));
    assign last_f_c     = (f_idx_q == F_W'(FEAT_LEN - 1));
    assign last_s_c     = (s_idx_q == S_W'(NUM_SHAPES - 1));
    assign ld_kern_ok_c = (state_q == S_IDLE) && bus.ld_valid && bus.ld_kernel
                          && (32'(bus.ld_addr) < NUM_KERNELS);
    assign ld_wt_ok_c   = (state_q == S_IDLE) && bus.ld_valid && !bus.ld_kernel
                          && (32'(bus.ld_addr) < NUM_WORDS);

    // Per-kernel window dot product, scaling and running pool maximum
    always_comb begin
        for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
            sum_c[k] = '0;
            for (int unsigned i = 0; i < 4; i++) begin
                sum_c[k] = sum_c[k] + SUM_W'(16'(bus.pixels[i]) * 16'(kernel_q[k][i*8 +: 8]));
            end
`ifdef NN_CONV_SAT_EN
            conv_c[k] = (sum_c[k][SUM_W-1:16] != '0) ? 8'hFF : sum_c[k][15:8];
`else
            conv_c[k] = sum_c[k][17:10];
`endif
            pool_nxt_c[k] = ((pool_pos_q == '0) || (conv_c[k] > pool_q[k])) ? conv_c[k] : pool_q[k];
        end
    end

    // One fully connected MAC term: feature f against weight byte of shape s
    always_comb begin
        w_addr_c = A_W'(32'(s_idx_q) * WPS + 32'(f_idx_q >> 2));
        w_word_c = weight_q[w_addr_c];
        w_byte_c = w_word_c[{f_idx_q[1:0], 3'b000} +: 8];
        prod_c   = 16'(feat_q[f_idx_q]) * 16'(w_byte_c);
        total_c  = acc_q + ACC_W'(prod_c);
        better_c = (s_idx_q == '0) || (total_c > best_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            pix_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pix_ready_q <= pix_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.classify)           state_d = S_CONV;
            S_CONV:  if (accept_c && last_win_c) state_d = S_FC;
            S_FC:    if (last_f_c && last_s_c)   state_d = S_RES;
            S_RES:   if (bus.res_ready)          state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // Status flags are computed from the next state so they leave a register
    always_comb begin
        busy_d      = 1'b0;
        pix_ready_d = 1'b0;
        res_valid_d = 1'b0;
        case (state_d)
            S_CONV:  begin busy_d = 1'b1; pix_ready_d = 1'b1; end
            S_FC:    busy_d = 1'b1;
            S_RES:   begin busy_d = 1'b1; res_valid_d = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
                kernel_q[k] <= '0;
                pool_q[k]   <= '0;
            end
            for (int unsigned w = 0; w < NUM_WORDS; w++) weight_q[w] <= '0;
            for (int unsigned f = 0; f < FEAT_LEN; f++)  feat_q[f]   <= '0;
            pool_pos_q <= '0;
            group_q    <= '0;
            f_idx_q    <= '0;
            s_idx_q    <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            result_q   <= '0;
        end else begin
            if (ld_kern_ok_c) kernel_q[K_W'(bus.ld_addr)] <= bus.ld_data;
            if (ld_wt_ok_c)   weight_q[A_W'(bus.ld_addr)] <= bus.ld_data;
            case (state_q)
                S_IDLE: begin
                    pool_pos_q <= '0;
                    group_q    <= '0;
                    f_idx_q    <= '0;
                    s_idx_q    <= '0;
                    acc_q      <= '0;
                end
                S_CONV: if (accept_c) begin
                    for (int unsigned k = 0; k < NUM_KERNELS; k++) begin
                        pool_q[k] <= pool_nxt_c[k];
                        if (pool_end_c) feat_q[F_W'(k * GROUPS) + F_W'(group_q)] <= pool_nxt_c[k];
                    end
                    if (pool_end_c) begin
                        pool_pos_q <= '0;
                        group_q    <= group_q + 1'b1;
                    end else begin
                        pool_pos_q <= pool_pos_q + 1'b1;
                    end
                end
                S_FC: begin
                    if (last_f_c) begin
                        f_idx_q <= '0;
                        acc_q   <= '0;
                        s_idx_q <= s_idx_q + 1'b1;
                        if (better_c) begin
                            best_q   <= total_c;
                            result_q <= 8'(s_idx_q);
                        end
                    end else begin
                        f_idx_q <= f_idx_q + 1'b1;
                        acc_q   <= total_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pix_ready = pix_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.score     = best_q;
endmodule
